// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the pipelined ALU's control states.
// The decode and hazard units import this package as well.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_NOP = 5'b00000,
        OP_INC = 5'b00100,
        OP_ADD = 5'b00101,
        OP_XOR = 5'b00110,
        OP_MUL = 5'b00111
    } aluop_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock.
// The product is held with done high until ack.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               ack_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Once cnt reaches WIDTH the accumulator is frozen until the result is taken.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != LAST_CNT) begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end else if (ack_i) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == LAST_CNT);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_pipelined.sv
// Handshaked ALU with a single registered output slot, status flags and tag pass-through.
// Single-cycle ops load the slot on accept; MUL runs through the iterative multiplier.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    state_t             state_q, state_d;
    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               flagZ_q, flagZ_d;
    logic               flagC_q, flagC_d;
    logic               flagV_q, flagV_d;
    logic               flagErr_q, flagErr_d;
    logic [TAG_W-1:0]   mulTag_q;

    aluop_t             opCode;
    logic               slotFree;
    logic               accept;
    logic               isMul;
    logic               mulStart;
    logic               mulAck;
    logic               mulBusy;
    logic               mulDone;
    logic               loadSlot;
    logic [2*WIDTH-1:0] mulProduct;
    logic [WIDTH-1:0]   aluResult;
    logic               aluCarry;
    logic               aluErr;

    assign opCode   = aluop_t'(alu_op);
    assign isMul    = (opCode == OP_MUL);
    assign slotFree = !outValid_q || out_ready;
    assign in_ready = (state_q == S_IDLE) && !mulBusy && slotFree;
    assign accept   = in_valid && in_ready;
    assign mulStart = accept && isMul;

    // Single-cycle datapath; INC/ADD are evaluated one bit wider to expose the carry.
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        aluErr    = 1'b0;
        case (opCode)
            OP_NOP, OP_MUL: ;
            OP_INC:  {aluCarry, aluResult} = {1'b0, src_a} + {{WIDTH{1'b0}}, 1'b1};
            OP_ADD:  {aluCarry, aluResult} = {1'b0, src_a} + {1'b0, src_b};
            OP_XOR:  aluResult = src_a ^ src_b;
            default: aluErr = 1'b1;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mulStart),
        .a_i      (src_a),
        .b_i      (src_b),
        .ack_i    (mulAck),
        .busy_o   (mulBusy),
        .done_o   (mulDone),
        .product_o(mulProduct)
    );

    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        result_d   = result_q;
        tag_d      = tag_q;
        flagZ_d    = flagZ_q;
        flagC_d    = flagC_q;
        flagV_d    = flagV_q;
        flagErr_d  = flagErr_q;
        mulAck     = 1'b0;
        loadSlot   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && isMul) begin
                    state_d = S_MUL;
                end else if (accept) begin
                    loadSlot  = 1'b1;
                    result_d  = aluResult;
                    tag_d     = in_tag;
                    flagZ_d   = (aluResult == '0);
                    flagC_d   = aluCarry;
                    flagV_d   = 1'b0;
                    flagErr_d = aluErr;
                end
            end
            S_MUL: begin
                // A finished product waits here, frozen, until the output slot can take it.
                if (mulDone && slotFree) begin
                    mulAck    = 1'b1;
                    loadSlot  = 1'b1;
                    state_d   = S_IDLE;
                    result_d  = mulProduct[WIDTH-1:0];
                    tag_d     = mulTag_q;
                    flagZ_d   = (mulProduct[WIDTH-1:0] == '0);
                    flagC_d   = 1'b0;
                    flagV_d   = |mulProduct[2*WIDTH-1:WIDTH];
                    flagErr_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (loadSlot) begin
            outValid_d = 1'b1;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            outValid_q <= 1'b0;
            result_q   <= '0;
            tag_q      <= '0;
            flagZ_q    <= 1'b0;
            flagC_q    <= 1'b0;
            flagV_q    <= 1'b0;
            flagErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
            flagZ_q    <= flagZ_d;
            flagC_q    <= flagC_d;
            flagV_q    <= flagV_d;
            flagErr_q  <= flagErr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulTag_q <= '0;
        end else if (mulStart) begin
            mulTag_q <= in_tag;
        end
    end

    assign out_valid = outValid_q;
    assign result    = result_q;
    assign out_tag   = tag_q;
    assign flag_z    = flagZ_q;
    assign flag_c    = flagC_q;
    assign flag_v    = flagV_q;
    assign flag_err  = flagErr_q;

endmodule

// File: tb/tb_alu_pipelined.sv
// Scoreboard bench for alu_pipelined: directed scenarios followed by randomized traffic
// with random back-pressure, all checked against an arithmetic reference model.
module tb_alu_pipelined;

    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    alu_op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [TW-1:0] out_tag;
    logic          flag_z, flag_c, flag_v, flag_err;

    typedef struct packed {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
        logic          z;
        logic          c;
        logic          v;
        logic          err;
    } expect_t;

    expect_t sbQueue[$];
    int      nCompared   = 0;
    int      nMismatched = 0;
    int      readyMode   = 0;

    alu_pipelined #(
        .WIDTH(W),
        .TAG_W(TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .flag_err (flag_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model straight from the opcode table, using wide integer arithmetic.
    function automatic expect_t model(input logic [4:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [TW-1:0] tag);
        expect_t e;
        longint  full;
        longint  modulus;
        modulus = longint'(1) << W;
        e       = '0;
        e.tag   = tag;
        case (op)
            5'b00000: full = 0;
            5'b00100: begin full = longint'(a) + 1;           e.c = (full >= modulus); end
            5'b00101: begin full = longint'(a) + longint'(b); e.c = (full >= modulus); end
            5'b00110: full = longint'(a ^ b);
            5'b00111: begin full = longint'(a) * longint'(b); e.v = (full >= modulus); end
            default:  begin full = 0; e.err = 1'b1; end
        endcase
        e.result = W'(full % modulus);
        e.z      = ((full % modulus) == 0);
        return e;
    endfunction

    // Back-pressure generator: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every presented beat is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbQueue.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_beat: got result 0x%0h tag %0d, expected no output at %0t",
                         result, out_tag, $time);
            end else begin
                checkOutput("result",   32'(result),   32'(sbQueue[0].result));
                checkOutput("out_tag",  32'(out_tag),  32'(sbQueue[0].tag));
                checkOutput("flag_z",   32'(flag_z),   32'(sbQueue[0].z));
                checkOutput("flag_c",   32'(flag_c),   32'(sbQueue[0].c));
                checkOutput("flag_v",   32'(flag_v),   32'(sbQueue[0].v));
                checkOutput("flag_err", 32'(flag_err), 32'(sbQueue[0].err));
                if (out_ready) begin
                    void'(sbQueue.pop_front());
                end
            end
        end
    end

    // Presents one op, waits (bounded) for acceptance, and records the expected result.
    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag, output int waits);
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        in_tag   = tag;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waits);
        end else begin
            sbQueue.push_back(model(op, a, b, tag));
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int waits;
        int lowCount;
        logic [4:0] opList [6];

        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = '0;
        src_a    = '0;
        src_b    = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_result",    32'(result),    0);
        checkOutput("reset_out_tag",   32'(out_tag),   0);
        checkOutput("reset_flags",     32'({flag_z, flag_c, flag_v, flag_err}), 0);
        checkOutput("reset_in_ready",  32'(in_ready),  1);
        @(posedge clk);
        #1;

        applyStimulus(5'b00101, 8'd200, 8'd100, 4'd3, waits);
        @(negedge clk);
        checkOutput("add_latency_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;

        applyStimulus(5'b00100, 8'd255, 8'd0, 4'd1, waits);
        applyStimulus(5'b00110, 8'h5A, 8'h5A, 4'd2, waits);
        checkOutput("back_to_back_waits", 32'(waits), 0);
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(5'b00111, 8'd15, 8'd17, 4'd4, waits);
        lowCount = 0;
        @(negedge clk);
        while (!in_ready && lowCount < 50) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput("mul_in_ready_low_cycles", 32'(lowCount), 9);
        checkOutput("mul_done_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        applyStimulus(5'b00111, 8'd16, 8'd16, 4'd5, waits);
        repeat (12) @(posedge clk);
        #1;

        readyMode = 2;
        @(posedge clk);
        #2;
        applyStimulus(5'b00101, 8'd1, 8'd2, 4'd6, waits);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_in_ready",  32'(in_ready),  0);
            checkOutput("hold_result",    32'(result),    3);
        end
        readyMode = 0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        applyStimulus(5'b01111, 8'd9, 8'd9, 4'd7, waits);
        applyStimulus(5'b00000, 8'd9, 8'd9, 4'd8, waits);
        @(negedge clk);
        @(negedge clk);
        checkOutput("single_beat_idle", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        applyStimulus(5'b00111, 8'd7, 8'd9, 4'd9, waits);
        void'(sbQueue.pop_back());
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid_in_reset", 32'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready",  32'(in_ready),  1);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        repeat (15) @(negedge clk);
        checkOutput("abort_no_stale_result", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        opList[0] = 5'b00000;
        opList[1] = 5'b00100;
        opList[2] = 5'b00101;
        opList[3] = 5'b00110;
        opList[4] = 5'b00111;
        readyMode = 1;
        for (int n = 0; n < 150; n++) begin
            opList[5] = 5'($urandom);
            applyStimulus(opList[$urandom_range(0, 5)], W'($urandom), W'($urandom),
                          TW'($urandom), waits);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        readyMode = 0;
        lowCount  = 0;
        while (sbQueue.size() != 0 && lowCount < 100) begin
            @(posedge clk);
            lowCount++;
        end
        checkOutput("final_queue_empty", 32'(sbQueue.size()), 0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
